// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline control: stage registers, load-use stall detection,
// taken-branch flush, operand forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] IF_Instr,
    input  logic              IF_Valid,
    input  logic [RA_W-1:0]   ID_SrcA,
    input  logic [RA_W-1:0]   ID_SrcB,
    input  logic              ID_UsesB,
    input  logic [RA_W-1:0]   ID_Dst,
    input  logic              ID_WrEn,
    input  logic              ID_IsLoad,
    input  logic [DATA_W-1:0] EX_Result,
    input  logic [DATA_W-1:0] MEM_Data,
    input  logic              Branch_Taken,
    output logic [DATA_W-1:0] ID_Instr,
    output logic              ID_Valid,
    output logic              PC_LdEn,
    output logic [1:0]        Fwd_A,
    output logic [1:0]        Fwd_B,
    output logic [DATA_W-1:0] EXMEM_Result,
    output logic [RA_W-1:0]   WB_Dst,
    output logic              WB_WrEn,
    output logic [DATA_W-1:0] WB_Data,
    output logic [CNT_W-1:0]  Stall_Cnt
);

    logic [DATA_W-1:0] if_id_instr;
    logic              if_id_valid;

    logic [RA_W-1:0]   id_ex_src_a, id_ex_src_b, id_ex_dst;
    logic              id_ex_uses_b, id_ex_wren, id_ex_isload, id_ex_valid;

    logic [RA_W-1:0]   ex_mem_dst;
    logic              ex_mem_wren, ex_mem_isload, ex_mem_valid;
    logic [DATA_W-1:0] ex_mem_result;

    logic [RA_W-1:0]   mem_wb_dst;
    logic              mem_wb_wren, mem_wb_valid;
    logic [DATA_W-1:0] mem_wb_data;

    logic [CNT_W-1:0]  stall_cnt;
    logic              load_use;
    logic              stall;

    // A load in ID/EX cannot forward to the instruction right behind it, so that one waits a cycle.
    always_comb begin
        load_use = id_ex_valid && id_ex_isload && (id_ex_dst != '0) && if_id_valid &&
                   ((id_ex_dst == ID_SrcA) || (ID_UsesB && (id_ex_dst == ID_SrcB)));
        stall    = load_use && !Branch_Taken;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (Branch_Taken) begin
            if_id_instr <= '0;
            if_id_valid <= 1'b0;
        end else if (!stall) begin
            if_id_instr <= IF_Instr;
            if_id_valid <= IF_Valid;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset || Branch_Taken || stall) begin
            id_ex_src_a  <= '0;
            id_ex_src_b  <= '0;
            id_ex_uses_b <= 1'b0;
            id_ex_dst    <= '0;
            id_ex_wren   <= 1'b0;
            id_ex_isload <= 1'b0;
            id_ex_valid  <= 1'b0;
        end else begin
            id_ex_src_a  <= ID_SrcA;
            id_ex_src_b  <= ID_SrcB;
            id_ex_uses_b <= ID_UsesB;
            id_ex_dst    <= ID_Dst;
            id_ex_wren   <= ID_WrEn && if_id_valid;
            id_ex_isload <= ID_IsLoad && if_id_valid;
            id_ex_valid  <= if_id_valid;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            ex_mem_dst    <= '0;
            ex_mem_wren   <= 1'b0;
            ex_mem_isload <= 1'b0;
            ex_mem_result <= '0;
            ex_mem_valid  <= 1'b0;
            mem_wb_dst    <= '0;
            mem_wb_wren   <= 1'b0;
            mem_wb_data   <= '0;
            mem_wb_valid  <= 1'b0;
        end else begin
            ex_mem_dst    <= id_ex_dst;
            ex_mem_wren   <= id_ex_wren;
            ex_mem_isload <= id_ex_isload;
            ex_mem_result <= EX_Result;
            ex_mem_valid  <= id_ex_valid;
            mem_wb_dst    <= ex_mem_dst;
            mem_wb_wren   <= ex_mem_wren;
            mem_wb_data   <= ex_mem_isload ? MEM_Data : ex_mem_result;
            mem_wb_valid  <= ex_mem_valid;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // EX/MEM wins over MEM/WB since it holds the younger value; a load's data is not ready in EX/MEM.
    function automatic logic [1:0] fwd_sel(input logic [RA_W-1:0] src);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_mem_valid && ex_mem_wren && !ex_mem_isload && (ex_mem_dst != '0) && (ex_mem_dst == src))
            sel = 2'b01;
        else if (mem_wb_valid && mem_wb_wren && (mem_wb_dst != '0) && (mem_wb_dst == src))
            sel = 2'b10;
        return sel;
    endfunction

    always_comb begin
        Fwd_A = fwd_sel(id_ex_src_a);
        Fwd_B = 2'b00;
        if (id_ex_uses_b)
            Fwd_B = fwd_sel(id_ex_src_b);
    end

    assign ID_Instr     = if_id_instr;
    assign ID_Valid     = if_id_valid;
    assign PC_LdEn      = !stall;
    assign EXMEM_Result = ex_mem_result;
    assign WB_Dst       = mem_wb_dst;
    assign WB_WrEn      = mem_wb_valid && mem_wb_wren;
    assign WB_Data      = mem_wb_data;
    assign Stall_Cnt    = stall_cnt;

endmodule
